// File: rtl/stack_lifo_pop.sv
// 16 x 8 LIFO stack: register-array storage, saturating stack pointer,
// registered top-of-stack read port and full/empty/overflow/underflow status.
// A simultaneous push and pop replaces the top word, or passes data_in straight
// through when the stack is empty.
module stack_lifo_pop #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_push,
   input  logic                  i_pop,
   input  logic [DATA_WIDTH-1:0] i_data_in,
   output logic [DATA_WIDTH-1:0] o_data_out,
   output logic                  o_valid,
   output logic [ADDR_WIDTH:0]   o_count,
   output logic                  o_empty,
   output logic                  o_full,
   output logic                  o_overflow,
   output logic                  o_underflow
);

   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [ADDR_WIDTH:0]   r_sp;
   logic [DATA_WIDTH-1:0] r_data_out;
   logic                  r_valid;
   logic                  r_overflow;
   logic                  r_underflow;

   logic                  w_empty;
   logic                  w_full;
   logic [ADDR_WIDTH-1:0] w_wr_idx;
   logic [ADDR_WIDTH-1:0] w_top_idx;
   logic [DATA_WIDTH-1:0] w_top;
   logic                  w_do_push;
   logic                  w_do_replace;

   assign w_empty   = (r_sp == '0);
   assign w_full    = (r_sp == DEPTH_CNT);
   // When full, the low bits of sp are 0 and sp-1 wraps to DEPTH-1, which is
   // exactly the top slot; the push path is guarded by w_full.
   assign w_wr_idx  = r_sp[ADDR_WIDTH-1:0];
   assign w_top_idx = r_sp[ADDR_WIDTH-1:0] - 1'b1;
   assign w_top     = r_mem[w_top_idx];

   assign w_do_push    = !i_reset &&  i_push && !i_pop && !w_full;
   assign w_do_replace = !i_reset &&  i_push &&  i_pop && !w_empty;

   // Storage write port: new slot on push, top slot on replace; never cleared.
   always_ff @(posedge i_clock) begin
      if (w_do_push)
         r_mem[w_wr_idx] <= i_data_in;
      else if (w_do_replace)
         r_mem[w_top_idx] <= i_data_in;
   end

   // Pointer, read port and status pulses; reset beats any request.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_sp        <= '0;
         r_data_out  <= '0;
         r_valid     <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_valid     <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
         unique case ({i_push, i_pop})
            2'b10: begin
               if (w_full) r_overflow <= 1'b1;
               else        r_sp       <= r_sp + 1'b1;
            end
            2'b01: begin
               if (w_empty) begin
                  r_underflow <= 1'b1;
               end else begin
                  r_data_out <= w_top;
                  r_sp       <= r_sp - 1'b1;
                  r_valid    <= 1'b1;
               end
            end
            2'b11: begin
               // Replace returns the old top; on empty the input passes through.
               r_valid    <= 1'b1;
               r_data_out <= w_empty ? i_data_in : w_top;
            end
            default: ;
         endcase
      end
   end

   assign o_data_out  = r_data_out;
   assign o_valid     = r_valid;
   assign o_count     = r_sp;
   assign o_empty     = w_empty;
   assign o_full      = w_full;
   assign o_overflow  = r_overflow;
   assign o_underflow = r_underflow;

endmodule

// File: tb/tb_stack_lifo_pop.sv
// Directed bench for stack_lifo_pop. Stimulus pushes the hand-computed
// expected post-edge state into a queue; a monitor pops it after each edge
// and compares.
module tb_stack_lifo_pop;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       push = 1'b0;
   logic       pop = 1'b0;
   logic [7:0] din = 8'h00;
   logic [7:0] dout;
   logic       valid;
   logic [4:0] count;
   logic       empty;
   logic       full;
   logic       ovf;
   logic       udf;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      tag;
      logic       valid;
      logic [7:0] dout;
      logic [4:0] count;
      logic       ovf;
      logic       udf;
   } exp_t;

   exp_t exp_q[$];

   stack_lifo_pop dut (
      .i_clock     (clk),
      .i_reset     (rst),
      .i_push      (push),
      .i_pop       (pop),
      .i_data_in   (din),
      .o_data_out  (dout),
      .o_valid     (valid),
      .o_count     (count),
      .o_empty     (empty),
      .o_full      (full),
      .o_overflow  (ovf),
      .o_underflow (udf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // One clock: drive inputs, queue the expected state after the edge.
   task automatic step(input string tag, input logic r, input logic pu, input logic po,
                       input logic [7:0] d, input logic ev, input logic [7:0] ed,
                       input logic [4:0] ec, input logic eo, input logic eu);
      exp_t e;
      @(negedge clk);
      rst = r; push = pu; pop = po; din = d;
      e.tag = tag; e.valid = ev; e.dout = ed; e.count = ec; e.ovf = eo; e.udf = eu;
      exp_q.push_back(e);
   endtask

   // Monitor: every edge that has a queued expectation is checked 1 time unit later.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            #1;
            chk({e.tag, ".valid"}, 32'(valid), 32'(e.valid));
            chk({e.tag, ".data"},  32'(dout),  32'(e.dout));
            chk({e.tag, ".count"}, 32'(count), 32'(e.count));
            chk({e.tag, ".ovf"},   32'(ovf),   32'(e.ovf));
            chk({e.tag, ".udf"},   32'(udf),   32'(e.udf));
            chk({e.tag, ".empty"}, 32'(empty), 32'(e.count == 5'd0));
            chk({e.tag, ".full"},  32'(full),  32'(e.count == 5'd16));
         end
      end
   end

   initial begin
      // Reset and idle
      step("reset", 1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0);
      for (int i = 0; i < 3; i++) step("idle", 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0);

      // Basic LIFO order
      step("push11", 0, 1, 0, 8'h11, 0, 8'h00, 1, 0, 0);
      step("push22", 0, 1, 0, 8'h22, 0, 8'h00, 2, 0, 0);
      step("push33", 0, 1, 0, 8'h33, 0, 8'h00, 3, 0, 0);
      step("pop33",  0, 0, 1, 8'h00, 1, 8'h33, 2, 0, 0);
      step("pop22",  0, 0, 1, 8'h00, 1, 8'h22, 1, 0, 0);
      step("pop11",  0, 0, 1, 8'h00, 1, 8'h11, 0, 0, 0);

      // Fill, overflow, drain, underflow
      for (int i = 0; i < 16; i++)
         step("fill", 0, 1, 0, 8'(i), 0, 8'h11, 5'(i + 1), 0, 0);
      step("overflow", 0, 1, 0, 8'hAA, 0, 8'h11, 16, 1, 0);
      for (int i = 0; i < 16; i++)
         step("drain", 0, 0, 1, 8'h00, 1, 8'(15 - i), 5'(15 - i), 0, 0);
      step("underflow", 0, 0, 1, 8'h00, 0, 8'h00, 0, 0, 1);

      // Full-stack replace returns old top, count unchanged
      for (int i = 0; i < 16; i++)
         step("refill", 0, 1, 0, 8'(8'h40 + i), 0, 8'h00, 5'(i + 1), 0, 0);
      step("repl_full", 0, 1, 1, 8'hEE, 1, 8'h4F, 16, 0, 0);
      step("pop_ee",    0, 0, 1, 8'h00, 1, 8'hEE, 15, 0, 0);
      step("rst_fill",  1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0);

      // Replace on a non-empty stack
      step("push55", 0, 1, 0, 8'h55, 0, 8'h00, 1, 0, 0);
      step("push66", 0, 1, 0, 8'h66, 0, 8'h00, 2, 0, 0);
      step("repl77", 0, 1, 1, 8'h77, 1, 8'h66, 2, 0, 0);
      step("pop77",  0, 0, 1, 8'h00, 1, 8'h77, 1, 0, 0);
      step("pop55",  0, 0, 1, 8'h00, 1, 8'h55, 0, 0, 0);

      // Pass-through on empty
      step("passC3", 0, 1, 1, 8'hC3, 1, 8'hC3, 0, 0, 0);
      step("idle2",  0, 0, 0, 8'h00, 0, 8'hC3, 0, 0, 0);

      // Reset mid-sequence beats a pop and drops contents
      step("push9A",  0, 1, 0, 8'h9A, 0, 8'hC3, 1, 0, 0);
      step("pushBC",  0, 1, 0, 8'hBC, 0, 8'hC3, 2, 0, 0);
      step("rst_pop", 1, 0, 1, 8'h00, 0, 8'h00, 0, 0, 0);
      step("stale",   0, 0, 1, 8'h00, 0, 8'h00, 0, 0, 1);
      step("idle3",   0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0);

      // Let the monitor drain the queue, bounded
      begin
         int n = 0;
         while (exp_q.size() > 0 && n < 20) begin
            @(posedge clk);
            n++;
         end
         @(negedge clk);
         checks++;
         if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
         end
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/stack_lifo_pop.md
Name: stack_lifo_pop

Overview:
- Complete 16 x 8 LIFO stack. The write (push) side stores into a register array; this block adds the read (pop) side.
- Read side consists of a bidirectional stack pointer, a registered top-of-stack read port, and full/empty/error status.
- Sits between a producer that pushes bytes and a consumer that pops them in last-in-first-out order.

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- ADDR_WIDTH, 4, pointer width. Depth = 2**ADDR_WIDTH = 16.

Ports:
- clock  input  1  rising-edge clock, only clock in the block.
- reset  input  1  synchronous, active-high reset.
- push  input  1  write request, sampled on rising edge.
- pop  input  1  read request, sampled on rising edge.
- data_in  input  DATA_WIDTH  word to push.
- data_out  output  DATA_WIDTH  registered popped word.
- valid  output  1  one-cycle pulse: data_out updated by a pop this cycle.
- count  output  ADDR_WIDTH+1  number of stored words, 0..16.
- empty  output  1  count == 0.
- full  output  1  count == 16.
- overflow  output  1  one-cycle pulse: push rejected.
- underflow  output  1  one-cycle pulse: pop rejected.

Behaviour:
- Reset (synchronous, active-high, checked on the rising edge, highest priority):
  - sp/count = 0, data_out = 0, valid = 0, overflow = 0, underflow = 0.
  - empty = 1, full = 0.
  - Memory contents are not cleared. Reset overrides push/pop in the same cycle.
- Storage: mem[0..15], written only at index sp (push) or sp-1 (replace). No other write path.
- empty and full are combinational decodes of count and have no latency. All other outputs are registered.
- Edge cases, evaluated at each rising edge with reset = 0:
  - push=0, pop=0: no change. valid, overflow and underflow = 0.
  - push=1, pop=0, not full: mem[sp] <= data_in, sp <= sp+1. data_out held, valid = 0.
  - push=1, pop=0, full: nothing stored, sp held, overflow = 1 for one cycle.
  - push=0, pop=1, not empty: data_out <= mem[sp-1], sp <= sp-1, valid = 1 in the following cycle. Latency is 1 clock from the pop edge to data available.
  - push=0, pop=1, empty: data_out held, sp held, valid = 0, underflow = 1 for one cycle.
  - push=1, pop=1, not empty (includes full): replace.
    - data_out <= mem[sp-1] (old top), mem[sp-1] <= data_in.
    - sp unchanged, valid = 1, no overflow or underflow.
  - push=1, pop=1, empty: pass-through.
    - data_out <= data_in, valid = 1, sp stays 0, memory not written, no flags.
- Pointer never wraps. It saturates at 0 and 16 through the guards above.
- Back-to-back pops are allowed every cycle. valid stays high for each accepted pop.
- Reset asserted mid-sequence discards all contents logically (count = 0). A subsequent pop gives underflow and never returns stale data.
- Implementation is plain synchronous RTL: always block with if (reset), no asynchronous clear and no latches.

Test Plan:
- Reset then idle 3 cycles -> count=0, empty=1, full=0, data_out=0x00, valid=0, overflow=0, underflow=0.
- Push 0x11, 0x22, 0x33, then pop 3 times on consecutive cycles:
  - data_out = 0x33, 0x22, 0x11 on the cycles after each pop, valid high for 3 cycles.
  - count goes 3 -> 0, empty=1 at the end.
- Push 0x00..0x0F (16 words):
  - full=1, count=16.
  - 17th push of 0xAA -> overflow pulse, count stays 16.
  - Then 16 pops -> 0x0F down to 0x00.
  - 17th pop -> underflow pulse, data_out holds 0x00, valid=0.
- Stack holding 0x55, 0x66; push=pop=1 with data_in=0x77:
  - data_out=0x66, valid=1, count stays 2.
  - Next pop -> 0x77, following pop -> 0x55.
- Empty stack, push=pop=1 with data_in=0xC3 -> data_out=0xC3, valid=1, count=0, empty=1, no flags.
- Push 0x9A and 0xBC, assert reset together with pop -> count=0, data_out=0x00, valid=0. Next pop -> underflow=1, data_out=0x00.
